// File: rtl/ex_forward_hazard_unit_pkg.sv
// Shared types for the EX forwarding / hazard unit: operand-select encoding and shadow pipeline tag.
package rv_pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_NONE = '0;

endpackage

// File: rtl/ex_forward_hazard_unit_if.sv
// ID-stage hazard inputs and EX operand-select / stall / flush outputs of the forwarding unit.
interface ex_forward_hazard_unit_if #(parameter int CNT_W = 32);

  logic                         id_valid;
  logic [rv_pipe_pkg::REG_AW-1:0] id_rs1;
  logic [rv_pipe_pkg::REG_AW-1:0] id_rs2;
  logic                         id_uses_rs1;
  logic                         id_uses_rs2;
  logic [rv_pipe_pkg::REG_AW-1:0] id_rd;
  logic                         id_reg_write;
  logic                         id_mem_read;
  logic                         mem_stall;
  logic                         ex_redirect;
  logic [1:0]                   selOp1;
  logic [1:0]                   selOp2;
  logic                         pc_stall;
  logic                         id_ex_bubble;
  logic                         if_id_flush;
  logic [CNT_W-1:0]             stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, mem_stall, ex_redirect,
    input  selOp1, selOp2, pc_stall, id_ex_bubble, if_id_flush, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, mem_stall, ex_redirect,
    output selOp1, selOp2, pc_stall, id_ex_bubble, if_id_flush, stall_cycles
  );

endinterface

// File: rtl/ex_forward_hazard_unit_fwd.sv
// Per-operand forwarding source selection and load-use detection against the EX/MEM shadow tags.
module fwd_operand_sel
  import rv_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_uses,
  input  pipe_tag_t         i_ex_tag,
  input  pipe_tag_t         i_mem_tag,
  output fwd_sel_e          o_sel,
  output logic              o_load_hit
);

  logic w_rs_live;
  logic w_ex_match;
  logic w_mem_match;
  logic w_unused;

  // x0 never forwards, which also excludes producers whose rd is x0
  assign w_rs_live   = i_uses & (i_rs != '0);
  assign w_ex_match  = i_ex_tag.valid & (i_ex_tag.rd == i_rs);
  assign w_mem_match = i_mem_tag.valid & i_mem_tag.reg_write & (i_mem_tag.rd == i_rs);
  assign o_load_hit  = w_rs_live & w_ex_match & i_ex_tag.mem_read;
  assign w_unused    = i_mem_tag.mem_read;

  always_comb begin
    o_sel = FWD_REG;
    if (w_rs_live) begin
      if (w_ex_match & i_ex_tag.reg_write & ~i_ex_tag.mem_read) begin
        o_sel = FWD_MEM;
      end else if (w_mem_match) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_forward_hazard_unit.sv
// EX forwarding and load-use hazard control: shadow tag pipeline, registered operand selects, stall counter.
module ex_forward_hazard_unit
  import rv_pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    resetn,
  ex_forward_hazard_unit_if.slave bus
);

  pipe_tag_t        r_ex_tag;
  pipe_tag_t        r_mem_tag;
  pipe_tag_t        r_wb_tag;
  fwd_sel_e         r_sel1;
  fwd_sel_e         r_sel2;
  logic [CNT_W-1:0] r_stall_cnt;

  fwd_sel_e  w_sel1;
  fwd_sel_e  w_sel2;
  logic      w_hit1;
  logic      w_hit2;
  logic      w_load_use;
  logic      w_lu_stall;
  logic      w_issue;
  pipe_tag_t w_id_tag;
  logic      w_unused;

  fwd_operand_sel u_op1 (
    .i_rs       (bus.id_rs1),
    .i_uses     (bus.id_uses_rs1),
    .i_ex_tag   (r_ex_tag),
    .i_mem_tag  (r_mem_tag),
    .o_sel      (w_sel1),
    .o_load_hit (w_hit1)
  );

  fwd_operand_sel u_op2 (
    .i_rs       (bus.id_rs2),
    .i_uses     (bus.id_uses_rs2),
    .i_ex_tag   (r_ex_tag),
    .i_mem_tag  (r_mem_tag),
    .o_sel      (w_sel2),
    .o_load_hit (w_hit2)
  );

  assign w_id_tag   = '{valid: 1'b1, rd: bus.id_rd,
                        reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
  assign w_load_use = bus.id_valid & (w_hit1 | w_hit2);
  // A redirect squashes the dependent instruction, so its load-use stall never happens
  assign w_lu_stall = w_load_use & ~bus.ex_redirect & ~bus.mem_stall;
  assign w_issue    = bus.id_valid & ~w_load_use & ~bus.ex_redirect;

  assign bus.pc_stall     = bus.mem_stall | w_lu_stall;
  assign bus.id_ex_bubble = ~bus.mem_stall & (bus.ex_redirect | w_load_use);
  assign bus.if_id_flush  = ~bus.mem_stall & bus.ex_redirect;
  assign bus.selOp1       = r_sel1;
  assign bus.selOp2       = r_sel2;
  assign bus.stall_cycles = r_stall_cnt;

  // WB producers are handled by the register file bypass; the tag is kept for pipeline symmetry
  assign w_unused = ^r_wb_tag;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ex_tag    <= TAG_NONE;
      r_mem_tag   <= TAG_NONE;
      r_wb_tag    <= TAG_NONE;
      r_sel1      <= FWD_REG;
      r_sel2      <= FWD_REG;
      r_stall_cnt <= '0;
    end else if (!bus.mem_stall) begin
      r_wb_tag  <= r_mem_tag;
      r_mem_tag <= r_ex_tag;
      r_ex_tag  <= w_issue ? w_id_tag : TAG_NONE;
      r_sel1    <= w_issue ? w_sel1 : FWD_REG;
      r_sel2    <= w_issue ? w_sel2 : FWD_REG;
      if (w_lu_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_ex_forward_hazard_unit.sv
// Scoreboard bench for ex_forward_hazard_unit: directed hazard scenarios followed by random instruction streams.
module tb_ex_forward_hazard_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } ins_t;

  typedef struct {
    bit ps;
    bit bub;
    bit fl;
    int s1;
    int s2;
    int cnt;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];

  ins_t pipe[3];
  int   m_sel1;
  int   m_sel2;
  int   m_cnt;

  ex_forward_hazard_unit_if #(.CNT_W(CNT_W)) bus ();

  ex_forward_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_stall",     32'(bus.pc_stall),     32'(e.ps));
      chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e.bub));
      chk("if_id_flush",  32'(bus.if_id_flush),  32'(e.fl));
      chk("selOp1",       32'(bus.selOp1),       e.s1);
      chk("selOp2",       32'(bus.selOp2),       e.s2);
      chk("stall_cycles", 32'(bus.stall_cycles), e.cnt);
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_sel1 = 0;
    m_sel2 = 0;
    m_cnt  = 0;
  endfunction

  // Where the operand will come from once this ID instruction reaches EX
  function automatic int src(input int rs, input bit uses);
    if (!uses || rs == 0) return 0;
    if (pipe[0].v && pipe[0].we && !pipe[0].ld && pipe[0].rd == rs) return 2;
    if (pipe[1].v && pipe[1].we && pipe[1].rd == rs) return 1;
    return 0;
  endfunction

  task automatic step(input bit rn, input bit v, input int rs1, input int rs2,
                      input bit u1, input bit u2, input int rd, input bit we,
                      input bit ld, input bit ms, input bit red);
    exp_t e;
    bit   lu;
    bit   ok;
    @(posedge clk);
    #1;
    resetn           = rn;
    bus.id_valid     = v;
    bus.id_rs1       = 5'(rs1);
    bus.id_rs2       = 5'(rs2);
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = we;
    bus.id_mem_read  = ld;
    bus.mem_stall    = ms;
    bus.ex_redirect  = red;
    lu = v && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
         ((u1 && pipe[0].rd == rs1) || (u2 && pipe[0].rd == rs2));
    e.ps  = ms || (lu && !red);
    e.bub = !ms && (red || lu);
    e.fl  = !ms && red;
    e.s1  = m_sel1;
    e.s2  = m_sel2;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (!rn) begin
      model_reset();
    end else if (!ms) begin
      ok = v && !lu && !red;
      m_sel1 = ok ? src(rs1, u1) : 0;
      m_sel2 = ok ? src(rs2, u2) : 0;
      if (lu && !red && m_cnt < CMAX) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = ok ? '{1, rd, we, ld} : '{0, 0, 0, 0};
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    resetn = 1'b0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0;
    bus.id_uses_rs2 = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.mem_stall = 0; bus.ex_redirect = 0;
    repeat (2) @(posedge clk);
    model_reset();

    //        rn v  rs1 rs2 u1 u2 rd we ld ms red
    nop(1);
    step(1, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);   // add x5,x1,x2
    step(1, 1, 5, 3, 1, 1, 6, 1, 0, 0, 0);   // add x6,x5,x3 -> op1 from MEM
    nop(2);
    step(1, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);   // add x5
    nop(1);
    step(1, 1, 5, 5, 1, 1, 6, 1, 0, 0, 0);   // add x6,x5,x5 -> both from WB
    nop(2);
    step(1, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);   // lw x7
    step(1, 1, 7, 1, 1, 1, 8, 1, 0, 0, 0);   // add x8,x7,x1 stalls
    step(1, 1, 7, 1, 1, 1, 8, 1, 0, 0, 0);   // reissued after the bubble
    nop(2);
    step(1, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);   // lw x7
    step(1, 1, 7, 1, 1, 1, 8, 1, 0, 0, 1);   // dependent while EX redirects
    nop(2);
    step(1, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0);   // add x0
    step(1, 1, 0, 4, 1, 0, 9, 1, 0, 0, 0);   // addi x9,x0,4
    nop(2);
    step(1, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);   // lw x7
    step(1, 1, 7, 1, 1, 1, 8, 1, 0, 1, 0);   // hazard frozen by mem_stall
    step(1, 1, 7, 1, 1, 1, 8, 1, 0, 1, 0);
    step(1, 1, 7, 1, 1, 1, 8, 1, 0, 1, 0);
    step(0, 1, 7, 1, 1, 1, 8, 1, 0, 0, 0);   // reset
    nop(2);

    // Back-to-back dependent loads push the narrow counter into saturation
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0);
      step(1, 1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 85),
           $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3),
           ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
